// File: rtl/bip2_datapath.sv
// BIP-2 execution datapath: accumulator, add/sub ALU, data RAM and the
// registered Z/N status flags fed back to the control unit for branches.
module bip2_datapath #(
  parameter int MSB_ROM  = 11,
  parameter int MSB_Data = 16,
  parameter int LSB      = 0,
  parameter int SEL_A    = 2
) (
  input  logic                      Clock_i,
  input  logic                      RESET_i,
  input  logic [MSB_ROM-1:LSB]      DATA_im_i,
  input  logic [SEL_A-1:LSB]        SellA_i,
  input  logic                      SellB_i,
  input  logic                      Op_i,
  input  logic                      WrAcc_i,
  input  logic                      WrRam_i,
  input  logic [MSB_ROM-1:LSB]      Dbg_addr_i,
  output logic [MSB_Data-1:LSB]     Dbg_data_o,
  output logic [MSB_Data-1:LSB]     Acc_o,
  output logic                      z_o,
  output logic                      n_o
);

  localparam int RAM_WORDS = 1 << MSB_ROM;

  localparam logic [SEL_A-1:0] SRC_RAM  = 2'b00;
  localparam logic [SEL_A-1:0] SRC_IMM  = 2'b01;
  localparam logic [SEL_A-1:0] SRC_ALU  = 2'b10;

  logic [MSB_Data-1:LSB] acc;
  logic [MSB_Data-1:LSB] ram [0:RAM_WORDS-1];
  logic [MSB_Data-1:LSB] ram_rd;
  logic [MSB_Data-1:LSB] imm;
  logic [MSB_Data-1:LSB] opnd_b;
  logic [MSB_Data-1:LSB] alu_res;

  assign imm        = {{(MSB_Data-MSB_ROM){DATA_im_i[MSB_ROM-1]}}, DATA_im_i};
  assign ram_rd     = ram[DATA_im_i];
  assign Dbg_data_o = ram[Dbg_addr_i];
  assign Acc_o      = acc;

  // ALU: operand select and add/sub, wrapping at the data width
  always_comb begin
    opnd_b  = SellB_i ? imm : ram_rd;
    alu_res = Op_i ? (acc - opnd_b) : (acc + opnd_b);
  end

  // Accumulator and status flags; flags only follow arithmetic results
  always_ff @(posedge Clock_i) begin
    if (!RESET_i) begin
      acc <= '0;
      z_o <= 1'b0;
      n_o <= 1'b0;
    end else if (WrAcc_i) begin
      case (SellA_i)
        SRC_RAM: acc <= ram_rd;
        SRC_IMM: acc <= imm;
        SRC_ALU: begin
          acc <= alu_res;
          z_o <= (alu_res == '0);
          n_o <= alu_res[MSB_Data-1];
        end
        default: acc <= acc;
      endcase
    end
  end

  // RAM write of the pre-update accumulator; contents survive reset
  always_ff @(posedge Clock_i) begin
    if (RESET_i && WrRam_i) begin
      ram[DATA_im_i] <= acc;
    end
  end

endmodule

// File: tb/tb_bip2_datapath.sv
// Self-checking bench for bip2_datapath: directed scenarios followed by
// random strobe sequences, all compared against a behavioural model.
module tb_bip2_datapath;

  logic        clk;
  logic        reset_n;
  logic [10:0] data_im;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        op;
  logic        wr_acc;
  logic        wr_ram;
  logic [10:0] dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] acc;
  logic        z;
  logic        n;

  bip2_datapath dut (
    .Clock_i    (clk),
    .RESET_i    (reset_n),
    .DATA_im_i  (data_im),
    .SellA_i    (sel_a),
    .SellB_i    (sel_b),
    .Op_i       (op),
    .WrAcc_i    (wr_acc),
    .WrRam_i    (wr_ram),
    .Dbg_addr_i (dbg_addr),
    .Dbg_data_o (dbg_data),
    .Acc_o      (acc),
    .z_o        (z),
    .n_o        (n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [15:0] m_acc = 16'h0;
  logic        m_z   = 1'b0;
  logic        m_n   = 1'b0;
  logic [15:0] m_ram [0:2047];
  bit          ram_ok = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sext(input logic [10:0] d);
    return {{5{d[10]}}, d};
  endfunction

  // One instruction cycle: drive, check the old RAM word before the edge,
  // advance the model at the edge, check everything after it.
  task automatic cyc(input logic rst, input logic wa, input logic [1:0] sa,
                     input logic sb, input logic o, input logic wr,
                     input logic [10:0] d, input logic [10:0] dbg);
    logic [15:0] rd;
    logic [15:0] b;
    logic [15:0] res;
    @(negedge clk);
    reset_n  = rst;
    wr_acc   = wa;
    sel_a    = sa;
    sel_b    = sb;
    op       = o;
    wr_ram   = wr;
    data_im  = d;
    dbg_addr = dbg;
    #1;
    if (ram_ok) check("ram_pre", dbg_data, m_ram[dbg]);
    @(posedge clk);
    rd  = m_ram[d];
    b   = sb ? sext(d) : rd;
    res = o ? (m_acc - b) : (m_acc + b);
    if (!rst) begin
      m_acc = 16'h0;
      m_z   = 1'b0;
      m_n   = 1'b0;
    end else begin
      if (wr) m_ram[d] = m_acc;
      if (wa) begin
        case (sa)
          2'b00: m_acc = rd;
          2'b01: m_acc = sext(d);
          2'b10: begin
            m_acc = res;
            m_z   = (res == 16'h0);
            m_n   = res[15];
          end
          default: ;
        endcase
      end
    end
    #1;
    check("acc", acc, m_acc);
    check("z", 16'(z), 16'(m_z));
    check("n", 16'(n), 16'(m_n));
    if (ram_ok) check("ram_post", dbg_data, m_ram[dbg]);
  endtask

  task automatic ldi(input logic [10:0] d);
    cyc(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, d, d);
  endtask
  task automatic sto(input logic [10:0] a);
    cyc(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, a, a);
  endtask
  task automatic ld(input logic [10:0] a);
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, a, a);
  endtask
  task automatic alu_i(input logic o, input logic [10:0] d);
    cyc(1'b1, 1'b1, 2'b10, 1'b1, o, 1'b0, d, d);
  endtask
  task automatic alu_m(input logic o, input logic [10:0] a);
    cyc(1'b1, 1'b1, 2'b10, 1'b0, o, 1'b0, a, a);
  endtask
  task automatic dbl(input logic [10:0] t);
    sto(t);
    alu_m(1'b0, t);
  endtask

  logic [15:0] saved;

  initial begin
    reset_n = 1'b0; wr_acc = 1'b0; sel_a = 2'b00; sel_b = 1'b0; op = 1'b0;
    wr_ram = 1'b0; data_im = '0; dbg_addr = '0;

    // reset dominates an LDI strobe
    cyc(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 11'h005, 11'h005);
    cyc(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 11'h005, 11'h005);
    check("rst_acc", acc, 16'h0000);
    check("rst_z", 16'(z), 16'h0);
    check("rst_n", 16'(n), 16'h0);
    ldi(11'h005);
    check("ldi_after_rst", acc, 16'h0005);

    // fill RAM: each cycle stores the old ACC while loading a new immediate
    for (int a = 0; a < 2048; a++)
      cyc(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 11'(a), 11'(a));
    ram_ok = 1'b1;

    ldi(11'h7FF);
    check("ldi_sext_neg", acc, 16'hFFFF);
    check("ldi_z_hold", 16'(z), 16'h0);
    ldi(11'h3FF);
    check("ldi_sext_pos", acc, 16'h03FF);

    // build 0x1234, store and reload it
    ldi(11'h246);
    dbl(11'h7F0); dbl(11'h7F0); dbl(11'h7F0);
    alu_i(1'b0, 11'h004);
    check("acc_1234", acc, 16'h1234);
    sto(11'h010);
    check("sto_word", dbg_data, 16'h1234);
    ldi(11'h000);
    ld(11'h010);
    check("ld_word", acc, 16'h1234);

    ldi(11'h005);
    alu_i(1'b1, 11'h005);
    check("subi_zero_acc", acc, 16'h0000);
    check("subi_zero_z", 16'(z), 16'h1);
    check("subi_zero_n", 16'(n), 16'h0);
    alu_i(1'b1, 11'h001);
    check("subi_neg_acc", acc, 16'hFFFF);
    check("subi_neg_z", 16'(z), 16'h0);
    check("subi_neg_n", 16'(n), 16'h1);
    ldi(11'h003);
    check("ldi_flags_z", 16'(z), 16'h0);
    check("ldi_flags_n", 16'(n), 16'h1);

    // 0x7FFF + 1 and 0xFFFF + 1
    ldi(11'h400);
    for (int i = 0; i < 5; i++) dbl(11'h7F1);
    alu_i(1'b1, 11'h001);
    check("acc_7fff", acc, 16'h7FFF);
    alu_i(1'b0, 11'h001);
    check("wrap_pos_acc", acc, 16'h8000);
    check("wrap_pos_n", 16'(n), 16'h1);
    check("wrap_pos_z", 16'(z), 16'h0);
    ldi(11'h7FF);
    alu_i(1'b0, 11'h001);
    check("wrap_ff_acc", acc, 16'h0000);
    check("wrap_ff_z", 16'(z), 16'h1);

    // simultaneous store and load at one address
    ldi(11'h055);
    sto(11'h020);
    ldi(11'h0AA);
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 11'h020, 11'h020);
    check("simul_acc", acc, 16'h0055);
    check("simul_ram", dbg_data, 16'h00AA);

    // reset blocks a pending store
    saved = m_ram[11'h030];
    ldi(11'h1AB);
    cyc(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 11'h030, 11'h030);
    check("rst_no_write", dbg_data, saved);
    check("rst_acc2", acc, 16'h0000);

    // random instruction streams
    for (int i = 0; i < 600; i++) begin
      logic [10:0] d;
      logic [10:0] g;
      d = 11'($urandom_range(0, 2047));
      g = ($urandom_range(0, 3) == 0) ? d : 11'($urandom_range(0, 2047));
      cyc(($urandom_range(0, 31) != 0), 1'($urandom), 2'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), d, g);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
